// File: rtl/lc3_controller_if.sv
// Control bus between the LC-3 sequencing controller and the datapath/memory side.
// master = controller, slave = datapath and memory completion sources.
interface lc3_controller_if;
   logic        complete_instr;
   logic        complete_data;
   logic [15:0] IR;
   logic [2:0]  psr;
   logic        enable_fetch;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic        enable_updatePC;
   logic        br_taken;
   logic [1:0]  mem_state;
   logic [15:0] instr_count;
   logic        timeout;

   modport master (
      input  complete_instr, complete_data, IR, psr,
      output enable_fetch, enable_decode, enable_execute, enable_writeback,
             enable_updatePC, br_taken, mem_state, instr_count, timeout
   );

   modport slave (
      output complete_instr, complete_data, IR, psr,
      input  enable_fetch, enable_decode, enable_execute, enable_writeback,
             enable_updatePC, br_taken, mem_state, instr_count, timeout
   );
endinterface

// File: rtl/lc3_controller.sv
// LC-3 multicycle sequencing FSM: fetch/decode/execute/memory/writeback/PC update,
// with a per-wait-state timeout guard and a retired-instruction counter.
module lc3_controller #(
   parameter int          WAIT_LIMIT      = 255,
   parameter logic [15:0] INSTR_COUNT_RST = 16'h0000
) (
   input  logic             controller_clock,
   input  logic             controller_reset,
   lc3_controller_if.master bus
);
   localparam int CW = $clog2(WAIT_LIMIT + 1);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM_IND,
      S_MEM_READ, S_MEM_WRITE, S_WRITEBACK, S_UPDATE_PC
   } state_t;

   state_t        r_state, w_next;
   logic [CW-1:0] r_wait;
   logic [3:0]    r_opcode;
   logic [2:0]    r_nzp;
   logic          w_wait_last, w_timeout_evt, w_br_next;
   logic [1:0]    w_mem_next;
   logic          r_en_fetch, r_en_decode, r_en_execute, r_en_writeback, r_en_updatepc;
   logic          r_br_taken, r_timeout;
   logic [1:0]    r_mem_state;
   logic [15:0]   r_instr_count;
   logic          w_ir_unused;

   assign w_ir_unused = ^bus.IR[8:0];

   always_ff @(posedge controller_clock or posedge controller_reset) begin
      if (controller_reset) r_state <= S_IDLE;
      else                  r_state <= w_next;
   end

   // Completion is tested before the limit so a late completion always wins.
   always_comb begin
      w_next        = r_state;
      w_timeout_evt = 1'b0;
      w_wait_last   = (r_wait == CW'(WAIT_LIMIT - 1));
      unique case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH: begin
            if (bus.complete_instr)  w_next = S_DECODE;
            else if (w_wait_last) begin
               w_next        = S_UPDATE_PC;
               w_timeout_evt = 1'b1;
            end
         end
         S_DECODE: w_next = S_EXECUTE;
         S_EXECUTE: begin
            case (r_opcode)
               OP_ADD, OP_AND, OP_NOT, OP_LEA: w_next = S_WRITEBACK;
               OP_LD, OP_LDR:                  w_next = S_MEM_READ;
               OP_LDI, OP_STI:                 w_next = S_MEM_IND;
               OP_ST, OP_STR:                  w_next = S_MEM_WRITE;
               default:                        w_next = S_UPDATE_PC;
            endcase
         end
         S_MEM_IND: begin
            if (bus.complete_data)
               w_next = (r_opcode == OP_LDI) ? S_MEM_READ : S_MEM_WRITE;
            else if (w_wait_last) begin
               w_next        = S_UPDATE_PC;
               w_timeout_evt = 1'b1;
            end
         end
         S_MEM_READ: begin
            if (bus.complete_data) w_next = S_WRITEBACK;
            else if (w_wait_last) begin
               w_next        = S_UPDATE_PC;
               w_timeout_evt = 1'b1;
            end
         end
         S_MEM_WRITE: begin
            if (bus.complete_data) w_next = S_UPDATE_PC;
            else if (w_wait_last) begin
               w_next        = S_UPDATE_PC;
               w_timeout_evt = 1'b1;
            end
         end
         S_WRITEBACK: w_next = S_UPDATE_PC;
         S_UPDATE_PC: w_next = S_FETCH;
         default:     w_next = S_IDLE;
      endcase
   end

   // Only EXECUTE of BR/JMP can lead to a taken branch; timeouts never do.
   always_comb begin
      w_br_next = 1'b0;
      if (r_state == S_EXECUTE) begin
         if (r_opcode == OP_BR)       w_br_next = |(r_nzp & bus.psr);
         else if (r_opcode == OP_JMP) w_br_next = 1'b1;
      end
   end

   always_comb begin
      w_mem_next = 2'd3;
      case (w_next)
         S_MEM_READ:  w_mem_next = 2'd0;
         S_MEM_IND:   w_mem_next = 2'd1;
         S_MEM_WRITE: w_mem_next = 2'd2;
         default:     w_mem_next = 2'd3;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with r_state.
   always_ff @(posedge controller_clock or posedge controller_reset) begin
      if (controller_reset) begin
         r_wait         <= '0;
         r_opcode       <= 4'd0;
         r_nzp          <= 3'd0;
         r_en_fetch     <= 1'b0;
         r_en_decode    <= 1'b0;
         r_en_execute   <= 1'b0;
         r_en_writeback <= 1'b0;
         r_en_updatepc  <= 1'b0;
         r_br_taken     <= 1'b0;
         r_mem_state    <= 2'd3;
         r_timeout      <= 1'b0;
         r_instr_count  <= INSTR_COUNT_RST;
      end else begin
         r_wait <= (w_next != r_state) ? '0 : r_wait + CW'(1);
         if (r_state == S_DECODE) begin
            r_opcode <= bus.IR[15:12];
            r_nzp    <= bus.IR[11:9];
         end
         r_en_fetch     <= (w_next == S_FETCH);
         r_en_decode    <= (w_next == S_DECODE);
         r_en_execute   <= (w_next == S_EXECUTE);
         r_en_writeback <= (w_next == S_WRITEBACK);
         r_en_updatepc  <= (w_next == S_UPDATE_PC);
         r_br_taken     <= w_br_next;
         r_mem_state    <= w_mem_next;
         if (w_timeout_evt)           r_timeout     <= 1'b1;
         if (r_state == S_UPDATE_PC)  r_instr_count <= r_instr_count + 16'd1;
      end
   end

   assign bus.enable_fetch     = r_en_fetch;
   assign bus.enable_decode    = r_en_decode;
   assign bus.enable_execute   = r_en_execute;
   assign bus.enable_writeback = r_en_writeback;
   assign bus.enable_updatePC  = r_en_updatepc;
   assign bus.br_taken         = r_br_taken;
   assign bus.mem_state        = r_mem_state;
   assign bus.instr_count      = r_instr_count;
   assign bus.timeout          = r_timeout;
endmodule
